// File: rtl/dat_xfer_ctrl.sv
// dat_xfer_ctrl: sequences multi-block DAT transfers with
// FIFO flow control, CRC/timeout/abort error handling.
module dat_xfer_ctrl #(
  parameter int TIMEOUT    = 1000,
  parameter int GAP_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        new_trans,
  input  logic        direction,
  input  logic [10:0] block_amount,
  input  logic        abort,
  input  logic        fifo_full,
  input  logic        fifo_empty,
  input  logic        blk_ack,
  input  logic        crc_ok,
  output logic        blk_start,
  output logic        blk_dir,
  output logic        busy,
  output logic        trans_done,
  output logic        trans_err,
  output logic [1:0]  err_code,
  output logic [10:0] blocks_done
);

  localparam int GAPS = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int CMAX = (TIMEOUT > GAPS) ? TIMEOUT : GAPS;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAPS);

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_CRC   = 2'b01;
  localparam logic [1:0] E_TOUT  = 2'b10;
  localparam logic [1:0] E_ABORT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RUN,
    ST_GAP,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t state_q, state_d;

  logic          nt_q;
  logic          nt_edge;
  logic [10:0]   amount_q;
  logic [CW-1:0] cnt_q;
  logic [10:0]   blocks_next;
  logic          fifo_ready;

  logic       accept;
  logic       blk_good;
  logic       cnt_load;
  logic       cnt_inc;
  logic       err_set;
  logic [1:0] err_d;

  assign nt_edge     = new_trans & ~nt_q;
  assign blocks_next = blocks_done + 11'd1;
  // Reads need room in the FIFO, writes need data in it.
  assign fifo_ready  = blk_dir ? ~fifo_full : ~fifo_empty;

  assign blk_start  = (state_q == ST_RUN) && (cnt_q == CNT_ONE);
  assign trans_done = (state_q == ST_DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    blk_good = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    err_set  = 1'b0;
    err_d    = E_NONE;
    unique case (state_q)
      ST_IDLE: begin
        if (nt_edge) begin
          accept  = 1'b1;
          state_d = (block_amount == 11'd0) ?
                    ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          err_set = 1'b1;
          err_d   = E_ABORT;
          state_d = ST_ERR;
        end else if (fifo_ready) begin
          cnt_load = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        // abort beats blk_ack, blk_ack beats timeout
        if (abort) begin
          err_set = 1'b1;
          err_d   = E_ABORT;
          state_d = ST_ERR;
        end else if (blk_ack) begin
          if (crc_ok) begin
            blk_good = 1'b1;
            cnt_load = 1'b1;
            state_d  = (blocks_next == amount_q) ?
                       ST_DONE : ST_GAP;
          end else begin
            err_set = 1'b1;
            err_d   = E_CRC;
            state_d = ST_ERR;
          end
        end else if (cnt_q == TO_LAST) begin
          err_set = 1'b1;
          err_d   = E_TOUT;
          state_d = ST_ERR;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_GAP: begin
        if (abort) begin
          err_set = 1'b1;
          err_d   = E_ABORT;
          state_d = ST_ERR;
        end else if (cnt_q == GAP_LAST) begin
          state_d = ST_WAIT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nt_q        <= 1'b0;
      amount_q    <= 11'd0;
      blk_dir     <= 1'b0;
      busy        <= 1'b0;
      trans_err   <= 1'b0;
      err_code    <= E_NONE;
      blocks_done <= 11'd0;
      cnt_q       <= '0;
    end else begin
      nt_q <= new_trans;
      if (accept) begin
        amount_q    <= block_amount;
        blk_dir     <= direction;
        blocks_done <= 11'd0;
        trans_err   <= 1'b0;
        err_code    <= E_NONE;
        busy        <= 1'b1;
      end
      if (blk_good) blocks_done <= blocks_next;
      if (err_set)  err_code    <= err_d;
      if (cnt_load)     cnt_q <= CNT_ONE;
      else if (cnt_inc) cnt_q <= cnt_q + CNT_ONE;
      if (state_q == ST_DONE) busy <= 1'b0;
      if (state_q == ST_ERR) begin
        busy      <= 1'b0;
        trans_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dat_xfer_ctrl.sv
// tb_dat_xfer_ctrl: scenario and randomized checks of
// dat_xfer_ctrl against a transfer-level expectation model.
module tb_dat_xfer_ctrl;

  localparam int TO  = 8;
  localparam int GAP = 2;
  localparam int TAIL = 6;
  localparam int LIMIT = 400;

  logic        clock = 1'b0;
  logic        reset;
  logic        new_trans;
  logic        direction;
  logic [10:0] block_amount;
  logic        abort;
  logic        fifo_full;
  logic        fifo_empty;
  logic        blk_ack;
  logic        crc_ok;
  logic        blk_start;
  logic        blk_dir;
  logic        busy;
  logic        trans_done;
  logic        trans_err;
  logic [1:0]  err_code;
  logic [10:0] blocks_done;

  int n_checks = 0;
  int n_fail   = 0;

  int starts, dones, min_sep, max_sep, first_start;
  int busy_fall, ack_cyc, dir_bad, stall_bad;

  dat_xfer_ctrl #(.TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
    .clock(clock), .reset(reset),
    .new_trans(new_trans), .direction(direction),
    .block_amount(block_amount), .abort(abort),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .blk_ack(blk_ack), .crc_ok(crc_ok),
    .blk_start(blk_start), .blk_dir(blk_dir),
    .busy(busy), .trans_done(trans_done),
    .trans_err(trans_err), .err_code(err_code),
    .blocks_done(blocks_done)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    new_trans = 1'b0;
    blk_ack   = 1'b0;
    abort     = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // One transfer: lat = ack delay after blk_start (0 = never),
  // stall = cycles the FIFO blocks, bad/abt = 1-based block.
  task automatic xfer(input int amt, input bit dir,
                      input int lat, input int stall,
                      input int bad, input int abt,
                      input bit hold_nt);
    int blk, s_last, ack_at;
    bit stalled;
    starts = 0; dones = 0; first_start = -1;
    min_sep = 1 << 30; max_sep = 0;
    busy_fall = -1; ack_cyc = -1;
    dir_bad = 0; stall_bad = 0;
    blk = 0; s_last = -1; ack_at = -1;
    tick();
    block_amount = 11'(amt);
    direction = dir;
    for (int c = 0; c < LIMIT; c++) begin
      if (c > 0) tick();
      if (c > 0 && blk_start) begin
        starts++;
        blk++;
        if (first_start < 0) first_start = c;
        else begin
          if (c - s_last < min_sep) min_sep = c - s_last;
          if (c - s_last > max_sep) max_sep = c - s_last;
        end
        s_last = c;
        if (lat > 0) ack_at = c + lat;
      end
      if (trans_done) dones++;
      if (c > 0 && busy && blk_dir !== dir) dir_bad++;
      if (c >= 1 && c <= stall &&
          (busy !== 1'b1 || blk_start !== 1'b0))
        stall_bad++;
      if (c > 0 && busy_fall < 0 && busy === 1'b0)
        busy_fall = c;
      new_trans = hold_nt ? 1'b1 : (c == 0);
      stalled = (c < stall);
      if (dir) begin
        fifo_full  = stalled;
        fifo_empty = 1'($urandom_range(0, 1));
      end else begin
        fifo_empty = stalled;
        fifo_full  = 1'($urandom_range(0, 1));
      end
      blk_ack = (c == ack_at);
      if (blk_ack) begin
        ack_cyc = c;
        crc_ok  = (blk != bad);
        abort   = (blk == abt);
      end else begin
        crc_ok  = 1'($urandom_range(0, 1));
        abort   = 1'b0;
      end
      if (busy_fall >= 0 && c >= busy_fall + TAIL) break;
    end
    n_checks++;
    if (busy_fall < 0) begin
      n_fail++;
      $display("FAIL xfer_bound: busy never fell in %0d cycles",
               LIMIT);
    end
    idle(2);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    new_trans = 0; direction = 0; block_amount = 0;
    abort = 0; fifo_full = 0; fifo_empty = 0;
    blk_ack = 0; crc_ok = 0;
    repeat (3) tick();
    n_checks++;
    if ({blk_start, blk_dir, busy, trans_done, trans_err,
         err_code, blocks_done} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %b required 0",
               {blk_start, blk_dir, busy, trans_done,
                trans_err, err_code, blocks_done});
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_normal_read;
    xfer(3, 1, 3, 0, 0, 0, 0);
    n_checks++;
    if (starts !== 3) begin
      n_fail++;
      $display("FAIL read_starts: got %0d required 3", starts);
    end
    n_checks++;
    if (min_sep !== 3 + GAP + 2 || max_sep !== 3 + GAP + 2) begin
      n_fail++;
      $display("FAIL read_sep: got %0d..%0d required %0d",
               min_sep, max_sep, 3 + GAP + 2);
    end
    n_checks++;
    if (blocks_done !== 11'd3 || dones !== 1) begin
      n_fail++;
      $display("FAIL read_done: got blocks %0d done %0d req 3 1",
               blocks_done, dones);
    end
    n_checks++;
    if (err_code !== 2'b00 || trans_err !== 1'b0 ||
        dir_bad !== 0 || first_start !== 2) begin
      n_fail++;
      $display("FAIL read_flags: got err %b/%b dir %0d fs %0d",
               err_code, trans_err, dir_bad, first_start);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    n_checks++;
    if (trans_err !== 1'b0 || err_code !== 2'b00 ||
        busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_abort: got err %b code %b busy %b",
               trans_err, err_code, busy);
    end
  endtask

  task automatic test_backpressure;
    xfer(2, 0, 3, 20, 0, 0, 0);
    n_checks++;
    if (stall_bad !== 0) begin
      n_fail++;
      $display("FAIL bp_stall: got %0d bad cycles required 0",
               stall_bad);
    end
    n_checks++;
    if (first_start !== 21) begin
      n_fail++;
      $display("FAIL bp_first: got %0d required 21",
               first_start);
    end
    n_checks++;
    if (blocks_done !== 11'd2 || dones !== 1 ||
        dir_bad !== 0) begin
      n_fail++;
      $display("FAIL bp_done: got %0d/%0d/%0d required 2/1/0",
               blocks_done, dones, dir_bad);
    end
  endtask

  task automatic test_crc;
    xfer(4, 1, 3, 0, 2, 0, 0);
    n_checks++;
    if (blocks_done !== 11'd1 || starts !== 2 ||
        dones !== 0) begin
      n_fail++;
      $display("FAIL crc_count: got %0d/%0d/%0d required 1/2/0",
               blocks_done, starts, dones);
    end
    n_checks++;
    if (trans_err !== 1'b1 || err_code !== 2'b01) begin
      n_fail++;
      $display("FAIL crc_err: got %b/%b required 1/01",
               trans_err, err_code);
    end
    n_checks++;
    if (busy_fall - ack_cyc > 2 || busy_fall <= ack_cyc) begin
      n_fail++;
      $display("FAIL crc_busy: fell %0d ack %0d required <=+2",
               busy_fall, ack_cyc);
    end
  endtask

  task automatic test_timeout;
    xfer(2, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if (err_code !== 2'b10 || trans_err !== 1'b1 ||
        blocks_done !== 11'd0 || starts !== 1) begin
      n_fail++;
      $display("FAIL tout: got %b/%b/%0d/%0d required 10/1/0/1",
               err_code, trans_err, blocks_done, starts);
    end
    n_checks++;
    if (busy_fall !== first_start + TO + 1) begin
      n_fail++;
      $display("FAIL tout_len: got %0d required %0d",
               busy_fall, first_start + TO + 1);
    end
    xfer(1, 0, TO - 1, 0, 0, 0, 0);
    n_checks++;
    if (err_code !== 2'b00 || blocks_done !== 11'd1 ||
        dones !== 1) begin
      n_fail++;
      $display("FAIL tout_edge_ack: got %b/%0d/%0d req 00/1/1",
               err_code, blocks_done, dones);
    end
    xfer(1, 1, TO, 0, 0, 0, 0);
    n_checks++;
    if (err_code !== 2'b10 || blocks_done !== 11'd0 ||
        dones !== 0) begin
      n_fail++;
      $display("FAIL tout_late_ack: got %b/%0d/%0d req 10/0/0",
               err_code, blocks_done, dones);
    end
  endtask

  task automatic test_abort;
    xfer(3, 0, 2, 1, 0, 2, 0);
    n_checks++;
    if (err_code !== 2'b11 || trans_err !== 1'b1 ||
        blocks_done !== 11'd1 || dones !== 0) begin
      n_fail++;
      $display("FAIL abort_ack: got %b/%b/%0d/%0d req 11/1/1/0",
               err_code, trans_err, blocks_done, dones);
    end
  endtask

  task automatic test_level_and_zero;
    xfer(1, 1, 2, 0, 0, 0, 1);
    n_checks++;
    if (starts !== 1 || dones !== 1) begin
      n_fail++;
      $display("FAIL level_hold: got %0d starts %0d done req 1 1",
               starts, dones);
    end
    xfer(0, 1, 3, 0, 0, 0, 0);
    n_checks++;
    if (starts !== 0 || dones !== 1 || err_code !== 2'b00 ||
        busy_fall !== 2) begin
      n_fail++;
      $display("FAIL zero_amt: got %0d/%0d/%b/%0d req 0/1/00/2",
               starts, dones, err_code, busy_fall);
    end
  endtask

  task automatic test_reset_mid;
    int n, k, bad;
    block_amount = 11'd3;
    direction = 1'b1;
    fifo_full = 1'b0;
    new_trans = 1'b1;
    tick();
    new_trans = 1'b0;
    n = 0; k = 0;
    while (k < 2 && n < 60) begin
      tick();
      n++;
      blk_ack = 1'b0;
      if (blk_start) begin
        k++;
        if (k == 1) begin
          blk_ack = 1'b1;
          crc_ok  = 1'b1;
        end
      end
    end
    blk_ack = 1'b0;
    n_checks++;
    if (k !== 2 || blocks_done !== 11'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_setup: got k %0d blocks %0d busy %b",
               k, blocks_done, busy);
    end
    reset = 1'b1;
    #2;
    n_checks++;
    if ({blk_start, blk_dir, busy, trans_done, trans_err,
         err_code, blocks_done} !== 18'd0) begin
      n_fail++;
      $display("FAIL rst_mid: got %b required 0",
               {blk_start, blk_dir, busy, trans_done,
                trans_err, err_code, blocks_done});
    end
    block_amount = 11'd0;
    new_trans = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (trans_done || trans_err || busy) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rst_quiet: got %0d active cycles req 0", bad);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (trans_done !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_first_edge: got done %b busy %b req 1 1",
               trans_done, busy);
    end
    idle(4);
  endtask

  task automatic test_random;
    for (int it = 0; it < 10; it++) begin
      int amt, lat, stall, fault, fblk;
      int e_blocks, e_starts, e_done;
      logic [1:0] e_code;
      bit dir;
      amt   = $urandom_range(1, 5);
      dir   = 1'($urandom_range(0, 1));
      lat   = $urandom_range(1, TO - 1);
      stall = $urandom_range(0, 4);
      fault = $urandom_range(0, 2);
      fblk  = $urandom_range(1, amt);
      xfer(amt, dir, lat, stall,
           (fault == 1) ? fblk : 0,
           (fault == 2) ? fblk : 0, 0);
      e_blocks = (fault == 0) ? amt : fblk - 1;
      e_starts = (fault == 0) ? amt : fblk;
      e_done   = (fault == 0) ? 1 : 0;
      e_code   = (fault == 0) ? 2'b00 :
                 (fault == 1) ? 2'b01 : 2'b11;
      n_checks++;
      if (blocks_done !== 11'(e_blocks) || starts !== e_starts ||
          dones !== e_done) begin
        n_fail++;
        $display("FAIL rnd%0d_count: got %0d/%0d/%0d req %0d/%0d/%0d",
                 it, blocks_done, starts, dones,
                 e_blocks, e_starts, e_done);
      end
      n_checks++;
      if (err_code !== e_code || trans_err !== (fault != 0) ||
          dir_bad !== 0 || stall_bad !== 0) begin
        n_fail++;
        $display("FAIL rnd%0d_flags: got %b/%b/%0d/%0d req %b/%0d",
                 it, err_code, trans_err, dir_bad, stall_bad,
                 e_code, fault != 0);
      end
      n_checks++;
      if (starts > 1 && min_sep < GAP + 1) begin
        n_fail++;
        $display("FAIL rnd%0d_sep: got %0d required >= %0d",
                 it, min_sep, GAP + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal_read();
    test_backpressure();
    test_crc();
    test_timeout();
    test_abort();
    test_level_and_zero();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
